// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift engine with runtime direction, stall and serial fill.
// A loaded word is shifted out over WIDTH advances while ser_in bits are assembled in par_out.
module piso_serializer #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             lsb_first,
    input  logic             advance,
    input  logic             ser_in,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] par_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;

    // State, shift register, bit counter and direction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state logic; the final shift of a word happens on the SHIFT->DONE edge
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shreg_d = din;
                    dir_d   = lsb_first;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (advance) begin
                    if (dir_q) begin
                        shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], ser_in};
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                dir_d   = 1'b0;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        sout_valid = (state_q == ST_SHIFT);
        sout       = sout_valid & (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]);
        last       = sout_valid & (cnt_q == CNT_LAST);
        busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        done       = (state_q == ST_DONE);
        par_out    = shreg_q;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer (WIDTH = 8).
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] din;
    logic         lsb_first;
    logic         advance;
    logic         ser_in;
    logic         sout;
    logic         sout_valid;
    logic         last;
    logic         busy;
    logic         done;
    logic [W-1:0] par_out;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .din        (din),
        .lsb_first  (lsb_first),
        .advance    (advance),
        .ser_in     (ser_in),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .par_out    (par_out)
    );

    always #5 clk = ~clk;

    // Sequences are written leftmost-first: bit 7 is the first bit in time.
    typedef struct {
        logic       lsb;
        logic [7:0] din;
        logic [7:0] sout_seq;
        logic [7:0] ser_seq;
        logic [7:0] par_exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int id, input logic lsb, input logic [7:0] d,
                           input logic [7:0] sseq, input logic [7:0] iseq,
                           input logic [7:0] pexp, input int glitch_cyc,
                           input bit load_in_done);
        lsb_first = lsb;
        din       = d;
        load      = 1'b1;
        advance   = 1'b1;
        ser_in    = 1'b0;
        tick();
        load      = 1'b0;
        din       = 8'hA5;
        lsb_first = ~lsb;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("v%0d sout c%0d", id, c), 32'(sout), 32'(sseq[8-c]));
            chk($sformatf("v%0d sout_valid c%0d", id, c), 32'(sout_valid), 32'd1);
            chk($sformatf("v%0d last c%0d", id, c), 32'(last), 32'(c == 8));
            chk($sformatf("v%0d done c%0d", id, c), 32'(done), 32'd0);
            ser_in = iseq[8-c];
            if (c == glitch_cyc) begin
                load = 1'b1;
                din  = 8'hFF;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        chk($sformatf("v%0d done c9", id), 32'(done), 32'd1);
        chk($sformatf("v%0d busy c9", id), 32'(busy), 32'd1);
        chk($sformatf("v%0d sout_valid c9", id), 32'(sout_valid), 32'd0);
        chk($sformatf("v%0d par_out c9", id), 32'(par_out), 32'(pexp));
        if (load_in_done) begin
            load = 1'b1;
            din  = 8'hFF;
        end
        tick();
        load = 1'b0;
        chk($sformatf("v%0d done c10", id), 32'(done), 32'd0);
        chk($sformatf("v%0d busy c10", id), 32'(busy), 32'd0);
        chk($sformatf("v%0d sout_valid c10", id), 32'(sout_valid), 32'd0);
        chk($sformatf("v%0d par_out c10", id), 32'(par_out), 32'(pexp));
    endtask

    logic [10:0] stall_seq;

    initial begin
        vecs[0] = '{lsb: 1'b0, din: 8'hB4, sout_seq: 8'b10110100, ser_seq: 8'b00000000, par_exp: 8'h00};
        vecs[1] = '{lsb: 1'b1, din: 8'hB4, sout_seq: 8'b00101101, ser_seq: 8'b00000000, par_exp: 8'h00};
        vecs[2] = '{lsb: 1'b0, din: 8'h00, sout_seq: 8'b00000000, ser_seq: 8'b11001010, par_exp: 8'hCA};
        vecs[3] = '{lsb: 1'b1, din: 8'h00, sout_seq: 8'b00000000, ser_seq: 8'b11001010, par_exp: 8'h53};
        vecs[4] = '{lsb: 1'b1, din: 8'h5A, sout_seq: 8'b01011010, ser_seq: 8'b10000001, par_exp: 8'h81};

        reset     = 1'b1;
        load      = 1'b0;
        din       = 8'h00;
        lsb_first = 1'b0;
        advance   = 1'b0;
        ser_in    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst sout", 32'(sout), 32'd0);
        chk("rst sout_valid", 32'(sout_valid), 32'd0);
        chk("rst last", 32'(last), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst par_out", 32'(par_out), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i].lsb, vecs[i].din, vecs[i].sout_seq,
                    vecs[i].ser_seq, vecs[i].par_exp, 0, 1'b0);
        end

        // MSB-first word with a third to fifth cycle stall: the third bit is held for four cycles
        stall_seq = 11'b10111110100;
        lsb_first = 1'b0;
        din       = 8'hB4;
        load      = 1'b1;
        advance   = 1'b1;
        ser_in    = 1'b0;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            chk($sformatf("stall sout c%0d", c), 32'(sout), 32'(stall_seq[11-c]));
            chk($sformatf("stall sout_valid c%0d", c), 32'(sout_valid), 32'd1);
            chk($sformatf("stall last c%0d", c), 32'(last), 32'(c == 11));
            chk($sformatf("stall done c%0d", c), 32'(done), 32'd0);
            advance = !(c >= 3 && c <= 5);
            tick();
        end
        advance = 1'b1;
        chk("stall done c12", 32'(done), 32'd1);
        tick();

        // Reset in cycle 4 abandons the word
        lsb_first = 1'b0;
        din       = 8'hB4;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
        end
        chk("rstmid busy c4", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid sout_valid", 32'(sout_valid), 32'd0);
        chk("rstmid sout", 32'(sout), 32'd0);
        chk("rstmid par_out", 32'(par_out), 32'd0);
        chk("rstmid done", 32'(done), 32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("rstmid no done +%0d", c), 32'(done), 32'd0);
        end
        run_vec(10, 1'b0, 8'hB4, 8'b10110100, 8'b00000000, 8'h00, 0, 1'b0);

        // Loads during SHIFT and DONE are ignored
        run_vec(11, 1'b0, 8'hB4, 8'b10110100, 8'b00000000, 8'h00, 3, 1'b1);
        tick();
        chk("ignload idle busy", 32'(busy), 32'd0);
        chk("ignload idle par_out", 32'(par_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift engine with a control FSM, bit counter, runtime shift direction, stall control and serial fill input.
- Successor to the fixed 9-bit, reset-loaded, left-only shifter.
- Feeds bit-serial arithmetic such as the sequential comparator and serial adder.
- Can also deserialise: bits entering on ser_in are assembled in par_out.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset; clears all state.
- load  input  1  start request; sampled only in IDLE.
- din  input  WIDTH  parallel word captured when load is accepted.
- lsb_first  input  1  direction select, sampled together with load. 0 = MSB first (shift left); 1 = LSB first (shift right).
- advance  input  1  shift enable while SHIFT; 0 stalls and holds the current bit.
- ser_in  input  1  fill bit shifted into the vacated end on each advance.
- sout  output  1  current serial bit. Equals shreg[WIDTH-1] (MSB-first) or shreg[0] (LSB-first) in SHIFT; 0 otherwise.
- sout_valid  output  1  high for every cycle in SHIFT.
- last  output  1  high in SHIFT when cnt == WIDTH-1, i.e. sout is the final bit.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse in DONE.
- par_out  output  WIDTH  current shift-register contents.

Behaviour:
- Reset (synchronous, highest priority, legal in any state):
  - state = IDLE, shreg = 0, cnt = 0, dir = 0.
  - All outputs 0 in the following cycle.
  - Reset mid-operation abandons the word; no done pulse.
- IDLE with load = 1:
  - shreg <= din; dir <= lsb_first; cnt <= 0; next state SHIFT.
  - The first bit is on sout in the next cycle (1-cycle latency).
- IDLE with load = 0: hold.
- SHIFT with advance = 1:
  - MSB-first: shreg <= {shreg[WIDTH-2:0], ser_in}.
  - LSB-first: shreg <= {ser_in, shreg[WIDTH-1:1]}.
  - cnt <= cnt + 1.
  - If cnt == WIDTH-1: go to DONE instead; the final shift still occurs and cnt resets to 0.
- SHIFT with advance = 0: shreg, cnt and state hold; sout, sout_valid and last are stable.
- DONE:
  - done = 1 for exactly one cycle, then unconditionally IDLE.
  - par_out holds the WIDTH received ser_in bits:
    - MSB-first: the first received bit is at bit WIDTH-1.
    - LSB-first: the first received bit is at bit 0.
- load in SHIFT or DONE is ignored; no queueing. Minimum spacing between accepted loads is WIDTH+2 cycles.
- lsb_first changes after acceptance have no effect until the next load.
- Throughput with advance held high: sout_valid for exactly WIDTH cycles, done in cycle WIDTH+1 after the load edge.
- cnt never exceeds WIDTH-1; there is no wrap inside SHIFT.

Test Plan:
- MSB-first run: WIDTH=8, din=8'hB4, lsb_first=0, advance=1, ser_in=0 → sout = 1,0,1,1,0,1,0,0 on cycles 1-8; last only on cycle 8; done on cycle 9; par_out=8'h00 in DONE.
- LSB-first run: din=8'hB4, lsb_first=1 → sout = 0,0,1,0,1,1,0,1; done on cycle 9.
- Stall: din=8'hB4 MSB-first, advance=0 on cycles 3-5 → sout holds 1 (bit 2) for those cycles; sout_valid stays high; done on cycle 12; bit sequence unchanged.
- Deserialise: din=8'h00 MSB-first, ser_in driven 1,1,0,0,1,0,1,0 on successive advances → par_out = 8'hCA in DONE. Same ser_in stream LSB-first → par_out = 8'h53.
- Reset mid-op: assert reset in cycle 4 of a run → next cycle busy=0, sout_valid=0, par_out=0, no done pulse. load on the following cycle restarts cleanly.
- Ignored load: pulse load with din=8'hFF in cycle 3 of an 8'hB4 run → serial sequence still 8'hB4's, done on cycle 9; load asserted in DONE is also not accepted.
